fft_stage_sequencer: RTL and testbench

Control and data-path front end for the 16-lane butterfly array. It does four things:
- Accepts a 32-sample frame as a 16-bit sample stream.
- Stores the frame in bit-reversed order in an internal register bank.
- Drives the array's `MAC_In1_2`/`MAC_In3` buses and writes `MAC_Out1_2` back for five radix-2 DIT stages, one stage per clock.
- Streams the transformed frame out in natural order.

It is the initiator/consumer on the other side of the array's flat-bus interface, and connects to it bit-for-bit.

---
 rtl/fft_stage_sequencer.sv | 146 ++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - frame load, five radix-2 DIT stages on the butterfly array, natural-order unload
module fft_stage_sequencer #(
    parameter int W = 16,
    parameter int N = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_data,
    output logic                   out_last,
    output logic                   ovf,
    output logic                   busy,
    input  logic [16*W-1:0]        tw_table,
    output logic [N*W-1:0]         MAC_In1_2,
    output logic [(N/2)*W-1:0]     MAC_In3,
    input  logic [N*W-1:0]         MAC_Out1_2,
    input  logic                   Overflow
);

    localparam int LANES = N / 2;

    localparam logic [1:0] ST_LOAD    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_UNLOAD  = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [2:0]   s_q, s_d;
    logic         ovf_q, ovf_d;
    logic [W-1:0] x_q [N];
    logic [W-1:0] x_d [N];

    function automatic logic [4:0] bitrev5(input logic [4:0] v);
        return {v[0], v[1], v[2], v[3], v[4]};
    endfunction

    // Upper butterfly leg for lane k in stage s; the lower leg sits 2^s above it.
    function automatic logic [4:0] lane_top(input logic [3:0] k, input logic [2:0] s);
        logic [4:0] kk;
        logic [4:0] j;
        kk = {1'b0, k};
        j  = kk & ((5'd1 << s) - 5'd1);
        return ((kk >> s) << (s + 3'd1)) + j;
    endfunction

    function automatic logic [3:0] lane_tw(input logic [3:0] k, input logic [2:0] s);
        logic [4:0] j;
        logic [4:0] t;
        j = {1'b0, k} & ((5'd1 << s) - 5'd1);
        t = j << (3'd4 - s);
        return t[3:0];
    endfunction

    always_comb begin
        MAC_In1_2 = '0;
        MAC_In3   = '0;
        if (state_q == ST_COMPUTE) begin
            for (int k = 0; k < LANES; k++) begin
                MAC_In1_2[2*W*k +: W]     = x_q[lane_top(k[3:0], s_q)];
                MAC_In1_2[2*W*k + W +: W] = x_q[lane_top(k[3:0], s_q) + (5'd1 << s_q)];
                MAC_In3[W*k +: W]         = tw_table[W*lane_tw(k[3:0], s_q) +: W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        ovf_d   = ovf_q;
        x_d     = x_q;
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    x_d[bitrev5(cnt_q)] = in_data;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = ST_COMPUTE;
                        s_d     = 3'd0;
                        cnt_d   = 5'd0;
                    end
                end
            end
            ST_COMPUTE: begin
                for (int k = 0; k < LANES; k++) begin
                    x_d[lane_top(k[3:0], s_q)]                 = MAC_Out1_2[2*W*k +: W];
                    x_d[lane_top(k[3:0], s_q) + (5'd1 << s_q)] = MAC_Out1_2[2*W*k + W +: W];
                end
                if (Overflow) begin
                    ovf_d = 1'b1;
                end
                if (s_q == 3'd4) begin
                    state_d = ST_UNLOAD;
                    s_d     = 3'd0;
                end else begin
                    s_d = s_q + 3'd1;
                end
            end
            ST_UNLOAD: begin
                if (out_ready) begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = ST_LOAD;
                        cnt_d   = 5'd0;
                        ovf_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
                cnt_d   = 5'd0;
                s_d     = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
            cnt_q   <= 5'd0;
            s_q     <= 3'd0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            ovf_q   <= ovf_d;
            x_q     <= x_d;
        end
    end

    assign in_ready  = (state_q == ST_LOAD);
    assign out_valid = (state_q == ST_UNLOAD);
    assign out_data  = out_valid ? x_q[cnt_q] : '0;
    assign out_last  = out_valid && (cnt_q == 5'd31);
    assign busy      = (state_q == ST_COMPUTE) || (state_q == ST_UNLOAD);
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb/tb_fft_stage_sequencer.sv - randomized bench with behavioural butterfly array and textbook DIT reference
module tb_fft_stage_sequencer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [15:0]  in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [15:0]  out_data;
    logic         out_last;
    logic         ovf;
    logic         busy;
    logic [255:0] tw_bus;
    logic [511:0] mac_in12;
    logic [255:0] mac_in3;
    logic [511:0] mac_out;
    logic         ovf_force = 1'b0;

    logic [15:0]  frame_d [32];
    logic [15:0]  tw_arr  [16];
    logic [15:0]  ref_out [32];
    logic [15:0]  snap    [5][32];
    logic         exp_ovf;
    logic         ovf_rand = 1'b0;
    int           n_checks = 0;
    int           n_fail = 0;

    fft_stage_sequencer #(.W(16), .N(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .ovf(ovf), .busy(busy), .tw_table(tw_bus),
        .MAC_In1_2(mac_in12), .MAC_In3(mac_in3), .MAC_Out1_2(mac_out), .Overflow(ovf_force)
    );

    always #5 clk = ~clk;

    // Array lane: t = (In2 * In3) >> 8, AddOut = In1 + t, SubOut = In1 - t, all wrapping.
    function automatic logic [31:0] bf(input logic [15:0] a, input logic [15:0] b, input logic [15:0] w);
        logic signed [31:0] p;
        logic [15:0] t;
        p = $signed(b) * $signed(w);
        t = p[23:8];
        return {a - t, a + t};
    endfunction

    always_comb begin
        tw_bus = '0;
        for (int i = 0; i < 16; i++) tw_bus[16*i +: 16] = tw_arr[i];
    end

    always_comb begin
        mac_out = '0;
        for (int k = 0; k < 16; k++)
            mac_out[32*k +: 32] = bf(mac_in12[32*k +: 16], mac_in12[32*k+16 +: 16], mac_in3[16*k +: 16]);
    end

    task automatic ref_model();
        logic [15:0] cur [32];
        logic [31:0] r;
        int br, half;
        for (int i = 0; i < 32; i++) begin
            br = 0;
            for (int b = 0; b < 5; b++) if (((i >> b) & 1) == 1) br = br | (1 << (4 - b));
            cur[br] = frame_d[i];
        end
        for (int st = 0; st < 5; st++) begin
            for (int i = 0; i < 32; i++) snap[st][i] = cur[i];
            half = 1 << st;
            for (int g = 0; g < 32; g += 2 * half) begin
                for (int j = 0; j < half; j++) begin
                    r = bf(cur[g+j], cur[g+j+half], tw_arr[j * (16 / half)]);
                    cur[g+j]      = r[15:0];
                    cur[g+j+half] = r[31:16];
                end
            end
        end
        for (int i = 0; i < 32; i++) ref_out[i] = cur[i];
    endtask

    task automatic load_frame(input int gap_mode);
        int idx = 0;
        int cyc = 0;
        logic acc;
        while (idx < 32 && cyc < 400) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL load_state: in_ready=%b busy=%b out_valid=%b required 1 0 0", in_ready, busy, out_valid);
            end
            n_checks++;
            if (ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL load_ovf: got %b required 0", ovf);
            end
            if (gap_mode == 1) in_valid = ((cyc % 3) != 2);
            else if (gap_mode == 2) in_valid = ($urandom_range(0, 3) != 0);
            else in_valid = 1'b1;
            in_data   = in_valid ? frame_d[idx] : 16'($urandom);
            ovf_force = ovf_rand ? 1'($urandom) : 1'b0;
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) idx++;
            cyc++;
        end
        n_checks++;
        if (idx != 32) begin
            n_fail++;
            $display("FAIL load_count: accepted %0d required 32", idx);
        end
    endtask

    task automatic compute_phase(input int ovf_mode, input bit probe);
        exp_ovf = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL compute_state c%0d: busy=%b in_ready=%b out_valid=%b required 1 0 0", c, busy, in_ready, out_valid);
            end
            n_checks++;
            if (ovf !== exp_ovf) begin
                n_fail++;
                $display("FAIL compute_ovf c%0d: got %b required %b", c, ovf, exp_ovf);
            end
            if (probe && c == 1) begin
                n_checks++;
                if (mac_in12[15:0] !== 16'd0 || mac_in12[31:16] !== 16'd16 || mac_in3[15:0] !== 16'h0100) begin
                    n_fail++;
                    $display("FAIL lane0_s0: in1=%h in2=%h in3=%h required 0000 0010 0100", mac_in12[15:0], mac_in12[31:16], mac_in3[15:0]);
                end
            end
            if (probe && c == 5) begin
                n_checks++;
                if (mac_in12[175:160] !== snap[4][5] || mac_in12[191:176] !== snap[4][21] || mac_in3[95:80] !== 16'h0105) begin
                    n_fail++;
                    $display("FAIL lane5_s4: in1=%h in2=%h in3=%h required %h %h 0105", mac_in12[175:160], mac_in12[191:176], mac_in3[95:80], snap[4][5], snap[4][21]);
                end
            end
            if (ovf_mode == 1) ovf_force = (c == 3);
            else if (ovf_mode == 2) ovf_force = 1'($urandom);
            else ovf_force = 1'b0;
            if (ovf_force) exp_ovf = 1'b1;
            in_valid = 1'($urandom);
            in_data  = 16'($urandom);
            @(posedge clk);
        end
    endtask

    task automatic unload_frame(input int rdy_mode);
        int n = 0;
        int cyc = 0;
        logic stalled = 1'b0;
        logic [15:0] hd = '0;
        logic hl = 1'b0;
        while (n < 32 && cyc < 400) begin
            @(negedge clk);
            if (cyc == 0) begin
                n_checks++;
                if (out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL latency: out_valid=%b in 6th cycle after last accept, required 1", out_valid);
                end
            end
            if (out_valid) begin
                n_checks++;
                if (in_ready !== 1'b0 || busy !== 1'b1 || ovf !== exp_ovf) begin
                    n_fail++;
                    $display("FAIL unload_state: in_ready=%b busy=%b ovf=%b required 0 1 %b", in_ready, busy, ovf, exp_ovf);
                end
            end
            if (stalled) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== hd || out_last !== hl) begin
                    n_fail++;
                    $display("FAIL hold: valid=%b data=%h last=%b required 1 %h %b", out_valid, out_data, out_last, hd, hl);
                end
            end
            if (rdy_mode == 1) out_ready = ((cyc % 3) == 0);
            else if (rdy_mode == 2) out_ready = 1'($urandom);
            else out_ready = 1'b1;
            in_valid  = 1'($urandom);
            in_data   = 16'($urandom);
            ovf_force = ovf_rand ? 1'($urandom) : 1'b0;
            if (out_valid && out_ready) begin
                n_checks++;
                if (out_data !== ref_out[n]) begin
                    n_fail++;
                    $display("FAIL data[%0d]: got %h required %h", n, out_data, ref_out[n]);
                end
                n_checks++;
                if (out_last !== (n == 31)) begin
                    n_fail++;
                    $display("FAIL last[%0d]: got %b required %b", n, out_last, (n == 31));
                end
                n++;
            end
            stalled = out_valid && !out_ready;
            hd = out_data;
            hl = out_last;
            @(posedge clk);
            cyc++;
        end
        n_checks++;
        if (n != 32) begin
            n_fail++;
            $display("FAIL unload_count: transfers %0d required 32", n);
        end
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reload: in_ready=%b out_valid=%b ovf=%b required 1 0 0", in_ready, out_valid, ovf);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        ovf_force = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_ctrl: in_ready=%b out_valid=%b out_last=%b busy=%b ovf=%b required 1 0 0 0 0", tag, in_ready, out_valid, out_last, busy, ovf);
        end
        n_checks++;
        if (mac_in12 !== '0 || mac_in3 !== '0) begin
            n_fail++;
            $display("FAIL %s_mac: buses not zero (in12 or=%b in3 or=%b) required 0", tag, |mac_in12, |mac_in3);
        end
    endtask

    task automatic rand_frame();
        for (int i = 0; i < 32; i++) frame_d[i] = 16'($urandom);
        for (int i = 0; i < 16; i++) tw_arr[i] = 16'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
    endtask

    task automatic test_impulse();
        for (int i = 0; i < 32; i++) frame_d[i] = '0;
        frame_d[0] = 16'h1234;
        for (int i = 0; i < 16; i++) tw_arr[i] = 16'($urandom);
        ref_model();
        load_frame(0);
        compute_phase(0, 1'b0);
        unload_frame(0);
    endtask

    task automatic test_pairing();
        for (int i = 0; i < 32; i++) frame_d[i] = 16'(i);
        for (int i = 0; i < 16; i++) tw_arr[i] = 16'(16'h0100 + i);
        ref_model();
        load_frame(0);
        compute_phase(0, 1'b1);
        unload_frame(0);
    endtask

    task automatic test_overflow();
        rand_frame();
        ref_model();
        load_frame(0);
        compute_phase(1, 1'b0);
        unload_frame(0);
    endtask

    task automatic test_backpressure();
        rand_frame();
        ref_model();
        load_frame(0);
        compute_phase(0, 1'b0);
        unload_frame(1);
    endtask

    task automatic test_gaps();
        rand_frame();
        ref_model();
        load_frame(1);
        compute_phase(0, 1'b0);
        unload_frame(0);
    endtask

    task automatic test_random();
        ovf_rand = 1'b1;
        for (int f = 0; f < 3; f++) begin
            rand_frame();
            ref_model();
            load_frame(2);
            compute_phase(2, 1'b0);
            unload_frame(2);
        end
        ovf_rand = 1'b0;
    endtask

    task automatic test_reset_mid();
        rand_frame();
        ref_model();
        load_frame(0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        #1;
        check_idle("rst_async");
        @(negedge clk);
        check_idle("rst_next");
        rst = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) frame_d[i] = '0;
        ref_model();
        load_frame(0);
        compute_phase(0, 1'b0);
        unload_frame(2);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) tw_arr[i] = '0;
        test_reset();
        test_impulse();
        test_pairing();
        test_overflow();
        test_backpressure();
        test_gaps();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
